cva6_pte_mem_responder: RTL
===========================

// Module: cva6_pte_mem_responder
// PURPOSE
//  Read-only memory responder for the dcache request port (dcache_req_t / dcache_rsp_t) used by the Sv32 PTW.
//  Answers the grant / tag_valid / rvalid handshake from a word-organised on-chip page-table store.
//  Sits in place of the dcache port in PTW/MMU subsystem benches and boot-ROM page-table configurations.
//  One outstanding request at a time; contents are loaded through a separate init write port.
// PARAMETERS
//  DEPTH      1024           number of 32-bit words in the store (power of 2, >=2)
//  BASE_ADDR  'h8000_0000    physical byte address of word 0 (riscv::PLEN bits, 4*DEPTH aligned)
//  LATENCY    1              cycles from tag cycle to rvalid (1..15)
//  LFSR_SEED  8'hA5          stall-LFSR reset seed, non-zero; used only with CVA6_PTE_RESP_STALL_EN
// PORTS
//  clk_i         in   1                  clock
//  rst_i         in   1                  asynchronous reset, active-high
//  req_port_i    in   dcache_req_t       request: data_req, address_index, address_tag, tag_valid, kill_req, data_we, data_size, data_id
//  rsp_port_o    out  dcache_rsp_t       response: data_gnt, data_rvalid, data_rdata (riscv::XLEN), data_id
//  init_we_i     in   1                  preload write strobe
//  init_widx_i   in   $clog2(DEPTH)      preload word index
//  init_wdata_i  in   32                 preload data
//  err_o         out  1                  sticky protocol/address error flag
// BEHAVIOUR
//  Reset: state IDLE; data_gnt=0, data_rvalid=0, data_rdata=0, data_id=0, err_o=0; array not reset.
//  FSM IDLE -> TAG -> [WAIT] -> RESP -> IDLE:
//  - IDLE: data_gnt = data_req (combinational, same cycle); on grant latch address_index, data_id, data_we -> TAG.
//  - TAG: wait for tag_valid; no timeout, hold TAG. On tag_valid:
//    form paddr={address_tag,index_q}; latch kill_req; read the array into rdata_q in this cycle.
//    Then -> RESP if LATENCY==1, else -> WAIT with counter=LATENCY-1.
//  - WAIT: counter decrements each cycle; go to RESP when it reaches 1.
//  - RESP: data_rvalid=1 for exactly one cycle with rdata_q and the latched data_id; -> IDLE.
//  - Timing: grant in cycle 0, tag in cycle 1, rvalid in cycle 1+LATENCY. Throughput is one request per LATENCY+2 cycles.
//  - No grant outside IDLE, so data_req is not granted in the RESP cycle.
//  Address rules:
//  - In range if BASE_ADDR <= paddr < BASE_ADDR+4*DEPTH; word index = (paddr-BASE_ADDR)>>2.
//  - Out of range: rdata=0, err_o set.
//  - paddr[1:0]!=0 or data_size!=2'b10: word at the aligned index is returned, err_o set.
//  kill_req in the tag cycle: the response still completes (rvalid at the normal time) with rdata=0; err_o is not set.
//  data_we=1: granted and completed normally with rdata=0; array not written; err_o set.
//  Init port:
//  - Writes the array on any cycle and in any state.
//  - Same-cycle init write and tag-cycle read of the same index: the read returns the old data.
//  - A write during WAIT is not reflected in the pending rdata_q.
//  err_o is sticky and is cleared only by rst_i.
//  rst_i mid-transaction (any state): FSM goes to IDLE and outputs take reset values immediately; no rvalid for the lost request.
// CONFIGURATION
//  CVA6_PTE_RESP_STALL_EN defined:
//  - Grant is withheld when lfsr[1:0]==2'b00.
//  - 8-bit Fibonacci LFSR, taps 8,6,5,4, reset to LFSR_SEED, advancing every cycle.
//  - The requester keeps data_req high; all other timing is unchanged.
//  CVA6_PTE_RESP_STALL_EN undefined: no LFSR logic; in IDLE data_gnt==data_req.
// TESTING
//  T1 preload idx 4 = 32'h2000_0001; req paddr BASE+0x10, LATENCY=1
//     -> gnt in cycle 0; rvalid in cycle 2 only; rdata=32'h2000_0001; err_o=0.
//  T2 LATENCY=3, same request
//     -> rvalid exactly 3 cycles after the tag cycle, one cycle wide; data_id echoed (e.g. 2'b01).
//  T3 req paddr BASE+4*DEPTH
//     -> rvalid with rdata=0; err_o=1 and stays 1 through subsequent good reads.
//  T4 kill_req=1 in the tag cycle
//     -> rvalid still issued at the normal time with rdata=0; err_o=0. Next request is granted in the following IDLE cycle.
//  T5 rst_i asserted during WAIT (LATENCY=4)
//     -> rvalid never seen for that request; next request after reset returns the preloaded data.
//  T6 CVA6_PTE_RESP_STALL_EN, LFSR_SEED=8'hA5, 64 back-to-back reads
//     -> gnt is low exactly in cycles where lfsr[1:0]==0; all 64 rdata match the model.

Source files
------------

// File: rtl/cva6_pte_mem_responder.sv
// Read-only Sv32 page-table store answering the dcache gnt/tag/rvalid handshake.
// Optional grant stalling via an LFSR is enabled with `define CVA6_PTE_RESP_STALL_EN.
package cva6_pte_resp_pkg;
  localparam int PLEN  = 34;
  localparam int XLEN  = 32;
  localparam int IDX_W = 12;
  localparam int TAG_W = PLEN - IDX_W;
  localparam int ID_W  = 2;

  typedef struct packed {
    logic [IDX_W-1:0] address_index;
    logic [TAG_W-1:0] address_tag;
    logic             data_req;
    logic             tag_valid;
    logic             kill_req;
    logic             data_we;
    logic [1:0]       data_size;
    logic [ID_W-1:0]  data_id;
  } dcache_req_t;

  typedef struct packed {
    logic             data_gnt;
    logic             data_rvalid;
    logic [ID_W-1:0]  data_id;
    logic [XLEN-1:0]  data_rdata;
  } dcache_rsp_t;
endpackage

module cva6_pte_mem_responder
  import cva6_pte_resp_pkg::*;
#(
  parameter int unsigned      DEPTH     = 1024,
  parameter logic [PLEN-1:0]  BASE_ADDR = 34'h0_8000_0000,
  parameter int unsigned      LATENCY   = 1,
  parameter logic [7:0]       LFSR_SEED = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  dcache_req_t              req_port_i,
  output dcache_rsp_t              rsp_port_o,
  input  logic                     init_we_i,
  input  logic [$clog2(DEPTH)-1:0] init_widx_i,
  input  logic [31:0]              init_wdata_i,
  output logic                     err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, TAG, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] index_q;
  logic [ID_W-1:0]  id_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic [XLEN-1:0]  rdata_q;
  logic             err;
  logic             stall;
  logic             gnt;
  logic [PLEN-1:0]  paddr;
  logic             in_range;
  logic             misal;
  logic [AW-1:0]    widx;
  logic [31:0]      mem [DEPTH];

`ifdef CVA6_PTE_RESP_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic [7:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign stall = 1'b0;
`endif

  // BASE_ADDR is 4*DEPTH aligned, so a range check is a compare of the upper bits.
  assign paddr    = {req_port_i.address_tag, index_q};
  assign in_range = (paddr[PLEN-1:AW+2] == BASE_ADDR[PLEN-1:AW+2]);
  assign widx     = paddr[AW+1:2];
  assign misal    = (paddr[1:0] != 2'b00) || (size_q != 2'b10);
  assign gnt      = (state == IDLE) && req_port_i.data_req && !stall && !rst_i;

  always_ff @(posedge clk_i) begin
    if (init_we_i) mem[init_widx_i] <= init_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      index_q <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt) begin
          index_q <= req_port_i.address_index;
          id_q    <= req_port_i.data_id;
          we_q    <= req_port_i.data_we;
          size_q  <= req_port_i.data_size;
          state   <= TAG;
        end
        TAG: if (req_port_i.tag_valid) begin
          // Killed requests still complete but silently return zero.
          if (req_port_i.kill_req) begin
            rdata_q <= '0;
          end else if (we_q || !in_range) begin
            rdata_q <= '0;
            err     <= 1'b1;
          end else begin
            rdata_q <= mem[widx];
            if (misal) err <= 1'b1;
          end
          if (LATENCY == 1) begin
            state <= RESP;
          end else begin
            cnt   <= 4'(LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_port_o.data_gnt    = gnt;
  assign rsp_port_o.data_rvalid = (state == RESP);
  assign rsp_port_o.data_id     = id_q;
  assign rsp_port_o.data_rdata  = rdata_q;
  assign err_o                  = err;
endmodule
